// File: rtl/pq_pop_stage_if.sv
// Signal bundle between the pq pop stage, the priority queue and the two downstream streams.
// The master modport is the stage itself; the slave modport is its environment.
interface pq_pop_stage_if #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  logic             pq_pop_o;
  logic             pq_pop_rdy_i;
  logic             pq_empty_i;
  logic [DW-1:0]    pq_data_i;
  logic             pq_overflow_i;
  logic [DW-1:0]    pq_data_overflow_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DW-1:0]    out_data_o;
  logic             ovf_valid_o;
  logic             ovf_ready_i;
  logic [DW-1:0]    ovf_data_o;
  logic             flush_i;
  logic             flush_done_o;
  logic             busy_o;
  logic [CNT_W-1:0] pop_cnt_o;
  logic [CNT_W-1:0] ovf_lost_o;

  modport master (
    output pq_pop_o,
    input  pq_pop_rdy_i, pq_empty_i, pq_data_i, pq_overflow_i, pq_data_overflow_i,
    output out_valid_o, out_data_o,
    input  out_ready_i,
    output ovf_valid_o, ovf_data_o,
    input  ovf_ready_i,
    input  flush_i,
    output flush_done_o, busy_o, pop_cnt_o, ovf_lost_o
  );

  modport slave (
    input  pq_pop_o,
    output pq_pop_rdy_i, pq_empty_i, pq_data_i, pq_overflow_i, pq_data_overflow_i,
    input  out_valid_o, out_data_o,
    output out_ready_i,
    input  ovf_valid_o, ovf_data_o,
    output ovf_ready_i,
    output flush_i,
    input  flush_done_o, busy_o, pop_cnt_o, ovf_lost_o
  );
endinterface

// File: rtl/pq_pop_stage.sv
// Drain stage of the priority queue: pops entries into a 2-entry output buffer, captures
// evicted entries into an overflow FIFO, and discards all queued entries on flush.
module pq_pop_stage #(
  parameter int DW        = 16,
  parameter int OVF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  pq_pop_stage_if.master bus
);
  localparam int AW = $clog2(OVF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             pop_q, pop_d;
  logic             flush_done_q, flush_done_d;

  logic [DW-1:0]    ob_mem_q [2];
  logic             ob_rd_ptr_q;
  logic             ob_wr_ptr_q;
  logic [1:0]       ob_cnt_q;
  logic [CNT_W-1:0] pop_cnt_q;

  logic [DW-1:0]    ovf_mem_q [OVF_DEPTH];
  logic [AW:0]      ovf_wp_q, ovf_rp_q;
  logic [CNT_W-1:0] ovf_lost_q;

  logic xfer_s, ob_wr_s, ob_rd_s, ob_clr_s;
  logic ovf_empty_s, ovf_full_s, ovf_rd_s, ovf_wr_s, ovf_drop_s;

  assign xfer_s   = pop_q & bus.pq_pop_rdy_i;
  assign ob_wr_s  = xfer_s & (state_q == S_POP);
  assign ob_rd_s  = (ob_cnt_q != 2'd0) & (state_q != S_FLUSH) & bus.out_ready_i;
  assign ob_clr_s = (state_q == S_IDLE) & bus.flush_i;

  assign ovf_empty_s = (ovf_wp_q == ovf_rp_q);
  assign ovf_full_s  = (ovf_wp_q[AW] != ovf_rp_q[AW]) &&
                       (ovf_wp_q[AW-1:0] == ovf_rp_q[AW-1:0]);
  assign ovf_rd_s    = ~ovf_empty_s & bus.ovf_ready_i;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign ovf_wr_s    = bus.pq_overflow_i & (~ovf_full_s | ovf_rd_s);
  assign ovf_drop_s  = bus.pq_overflow_i & ovf_full_s & ~ovf_rd_s;

  // FSM state register together with the registered pop request and flush-done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pop_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop_d;
      flush_done_q <= flush_done_d;
    end
  end

  // FSM next-state logic; flush wins over pop in IDLE
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush_i) begin
          state_d = S_FLUSH;
        end else if (!bus.pq_empty_i && (ob_cnt_q < 2'd2)) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        if (xfer_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_POP;
        end
      end
      S_FLUSH: begin
        if (bus.pq_empty_i && !xfer_s) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next value of the registered pop request
  always_comb begin
    pop_d = 1'b0;
    case (state_d)
      S_POP:   pop_d = 1'b1;
      S_FLUSH: pop_d = ~bus.pq_empty_i;
      default: pop_d = 1'b0;
    endcase
  end

  // Output buffer: 2-entry FIFO, emptied when a flush is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ob_mem_q[0] <= {DW{1'b0}};
      ob_mem_q[1] <= {DW{1'b0}};
      ob_rd_ptr_q <= 1'b0;
      ob_wr_ptr_q <= 1'b0;
      ob_cnt_q    <= 2'd0;
    end else if (ob_clr_s) begin
      ob_rd_ptr_q <= 1'b0;
      ob_wr_ptr_q <= 1'b0;
      ob_cnt_q    <= 2'd0;
    end else begin
      if (ob_wr_s) begin
        ob_mem_q[ob_wr_ptr_q] <= bus.pq_data_i;
        ob_wr_ptr_q           <= ~ob_wr_ptr_q;
      end
      if (ob_rd_s) begin
        ob_rd_ptr_q <= ~ob_rd_ptr_q;
      end
      case ({ob_wr_s, ob_rd_s})
        2'b10:   ob_cnt_q <= ob_cnt_q + 2'd1;
        2'b01:   ob_cnt_q <= ob_cnt_q - 2'd1;
        default: ob_cnt_q <= ob_cnt_q;
      endcase
    end
  end

  // Delivered-entry counter, wraps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_cnt_q <= {CNT_W{1'b0}};
    end else if (ob_rd_s) begin
      pop_cnt_q <= pop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Overflow FIFO with wrap-bit pointers and saturating drop counter; untouched by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OVF_DEPTH; i++) begin
        ovf_mem_q[i] <= {DW{1'b0}};
      end
      ovf_wp_q   <= {(AW+1){1'b0}};
      ovf_rp_q   <= {(AW+1){1'b0}};
      ovf_lost_q <= {CNT_W{1'b0}};
    end else begin
      if (ovf_wr_s) begin
        ovf_mem_q[ovf_wp_q[AW-1:0]] <= bus.pq_data_overflow_i;
        ovf_wp_q                    <= ovf_wp_q + {{AW{1'b0}}, 1'b1};
      end
      if (ovf_rd_s) begin
        ovf_rp_q <= ovf_rp_q + {{AW{1'b0}}, 1'b1};
      end
      if (ovf_drop_s && (ovf_lost_q != {CNT_W{1'b1}})) begin
        ovf_lost_q <= ovf_lost_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pq_pop_o     = pop_q;
  assign bus.out_valid_o  = (ob_cnt_q != 2'd0) & (state_q != S_FLUSH);
  assign bus.out_data_o   = ob_mem_q[ob_rd_ptr_q];
  assign bus.ovf_valid_o  = ~ovf_empty_s;
  assign bus.ovf_data_o   = ovf_mem_q[ovf_rp_q[AW-1:0]];
  assign bus.flush_done_o = flush_done_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.pop_cnt_o    = pop_cnt_q;
  assign bus.ovf_lost_o   = ovf_lost_q;
endmodule
